// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : exec_sequencer
//  Purpose  : Three-cycle IDLE/EXEC/WB sequencer owning rf write enable, NZP
//             flags and the instruction pointer of the 16-bit EXE datapath.
//             Optional macro PERF_CNT_EN builds the retired-instruction counter.
//  Revision : 1.0  initial release
// ============================================================================
module exec_sequencer #(
  parameter logic [15:0] IP_RESET = 16'h3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [4:0]       inst_type,
  input  logic [2:0]       inst_nzp,
  input  logic [15:0]      alu_res,
  input  logic [15:0]      target,
  output logic             rf_we,
  output logic             rf_link,
  output logic [2:0]       nzp,
  output logic [15:0]      ip,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [4:0] c_ty_br   = 5'b01001;
  localparam logic [4:0] c_ty_call = 5'b10001;
  localparam logic [4:0] c_ty_ret  = 5'b00000;

  state_t      state_q, state_d;
  logic [4:0]  type_q, type_d;
  logic [2:0]  mask_q, mask_d;
  logic [15:0] ip_q, ip_d;
  logic [2:0]  nzp_q, nzp_d;
  logic        rf_we_q, rf_we_d;
  logic        rf_link_q, rf_link_d;
  logic        illegal_q, illegal_d;
  logic        is_alu, is_call;

  // ALU group is 001xx
  assign is_alu  = (type_q[4:2] == 3'b001);
  assign is_call = (type_q == c_ty_call);

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    mask_d    = mask_q;
    ip_d      = ip_q;
    nzp_d     = nzp_q;
    rf_we_d   = 1'b0;
    rf_link_d = 1'b0;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (inst_valid) begin
          type_d  = inst_type;
          mask_d  = inst_nzp;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // write strobe is registered so it is glitch-free for the whole WB cycle
        state_d   = S_WB;
        rf_we_d   = is_alu | is_call;
        rf_link_d = is_call;
      end
      S_WB: begin
        state_d = S_IDLE;
        if (is_alu) begin
          nzp_d = {alu_res[15], alu_res == 16'h0000,
                   ~alu_res[15] & (alu_res != 16'h0000)};
          ip_d  = ip_q + 16'd1;
        end else if (type_q == c_ty_br) begin
          ip_d = (|(mask_q & nzp_q)) ? target : ip_q + 16'd1;
        end else if (is_call || type_q == c_ty_ret) begin
          ip_d = target;
        end else begin
          ip_d      = ip_q + 16'd1;
          illegal_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      type_q    <= 5'd0;
      mask_q    <= 3'd0;
      ip_q      <= IP_RESET;
      nzp_q     <= 3'b010;
      rf_we_q   <= 1'b0;
      rf_link_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      mask_q    <= mask_d;
      ip_q      <= ip_d;
      nzp_q     <= nzp_d;
      rf_we_q   <= rf_we_d;
      rf_link_q <= rf_link_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_WB) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign retired_cnt = cnt_q;
`else
  assign retired_cnt = '0;
`endif

  assign inst_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign rf_we      = rf_we_q;
  assign rf_link    = rf_link_q;
  assign nzp        = nzp_q;
  assign ip         = ip_q;
  assign illegal    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exec_sequencer
//  Purpose  : Directed self-checking bench for exec_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [4:0]  inst_type = 5'd0;
  logic [2:0]  inst_nzp = 3'd0;
  logic [15:0] alu_res = 16'd0;
  logic [15:0] target = 16'd0;
  logic        rf_we, rf_link, busy, illegal;
  logic [2:0]  nzp;
  logic [15:0] ip;
  logic [31:0] retired_cnt;

  int checks = 0;
  int errors = 0;

  // values captured while an instruction walks through the pipeline
  logic obs_ready_acc, obs_ready_exec, obs_ready_wb;
  logic obs_we_exec, obs_we_wb, obs_link_wb, obs_busy_exec, obs_busy_wb;

  exec_sequencer #(.IP_RESET(16'h3000), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_type(inst_type), .inst_nzp(inst_nzp), .alu_res(alu_res), .target(target),
    .rf_we(rf_we), .rf_link(rf_link), .nzp(nzp), .ip(ip), .busy(busy),
    .illegal(illegal), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // Called at posedge+1 with the DUT idle. Returns at posedge+1 either in WB
  // (stop_in_wb) or back in IDLE. Inputs are scrambled after accept so that
  // any failure to latch shows up.
  task automatic run_inst(input logic [4:0] t, input logic [2:0] m,
                          input logic [15:0] a, input logic [15:0] tg,
                          input logic stop_in_wb);
    inst_valid = 1'b1;
    inst_type  = t;
    inst_nzp   = m;
    @(posedge clk); #1;
    obs_ready_acc = inst_ready;
    inst_valid = 1'b0;
    inst_type  = 5'b11111;
    inst_nzp   = ~m;
    alu_res    = a;
    target     = tg;
    obs_ready_exec = inst_ready;
    obs_we_exec    = rf_we;
    obs_busy_exec  = busy;
    @(posedge clk); #1;
    obs_we_wb     = rf_we;
    obs_link_wb   = rf_link;
    obs_busy_wb   = busy;
    obs_ready_wb  = inst_ready;
    if (!stop_in_wb) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ip !== 16'h3000) begin errors++; $display("FAIL reset_ip got %h want 3000", ip); end
    checks++; if (nzp !== 3'b010) begin errors++; $display("FAIL reset_nzp got %b want 010", nzp); end
    checks++; if (inst_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", inst_ready); end
    checks++; if ({rf_we, rf_link, busy, illegal} !== 4'b0000) begin errors++;
      $display("FAIL reset_ctl got %b want 0000", {rf_we, rf_link, busy, illegal}); end
    checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", retired_cnt); end
  endtask

  task automatic test_alu;
    run_inst(5'b00110, 3'b000, 16'h8000, 16'h1234, 1'b0);
    checks++; if ({obs_we_exec, obs_busy_exec, obs_ready_exec} !== 3'b010) begin errors++;
      $display("FAIL alu_exec we/busy/ready got %b want 010", {obs_we_exec, obs_busy_exec, obs_ready_exec}); end
    checks++; if ({obs_we_wb, obs_link_wb, obs_busy_wb} !== 3'b101) begin errors++;
      $display("FAIL alu_wb we/link/busy got %b want 101", {obs_we_wb, obs_link_wb, obs_busy_wb}); end
    checks++; if ({nzp, ip} !== {3'b100, 16'h3001}) begin errors++;
      $display("FAIL alu_after nzp/ip got %b/%h want 100/3001", nzp, ip); end
    checks++; if ({inst_ready, rf_we, illegal} !== 3'b100) begin errors++;
      $display("FAIL alu_after ready/we/illegal got %b want 100", {inst_ready, rf_we, illegal}); end
  endtask

  task automatic test_branch;
    run_inst(5'b00100, 3'b000, 16'h0000, 16'h0000, 1'b0);
    checks++; if ({nzp, ip} !== {3'b010, 16'h3002}) begin errors++;
      $display("FAIL alu_zero nzp/ip got %b/%h want 010/3002", nzp, ip); end
    run_inst(5'b01001, 3'b010, 16'hFFFF, 16'h4000, 1'b0);
    checks++; if ({nzp, ip, obs_we_wb} !== {3'b010, 16'h4000, 1'b0}) begin errors++;
      $display("FAIL br_taken nzp/ip/we got %b/%h/%b want 010/4000/0", nzp, ip, obs_we_wb); end
    run_inst(5'b01001, 3'b101, 16'h0001, 16'h5555, 1'b0);
    checks++; if (ip !== 16'h4001) begin errors++; $display("FAIL br_not_taken got %h want 4001", ip); end
    run_inst(5'b01001, 3'b000, 16'h0001, 16'h5555, 1'b0);
    checks++; if (ip !== 16'h4002) begin errors++; $display("FAIL br_mask0 got %h want 4002", ip); end
    run_inst(5'b00111, 3'b000, 16'h0005, 16'h0000, 1'b0);
    checks++; if ({nzp, ip} !== {3'b001, 16'h4003}) begin errors++;
      $display("FAIL alu_pos nzp/ip got %b/%h want 001/4003", nzp, ip); end
    run_inst(5'b01001, 3'b001, 16'h8000, 16'h6000, 1'b0);
    checks++; if ({nzp, ip} !== {3'b001, 16'h6000}) begin errors++;
      $display("FAIL br_pos nzp/ip got %b/%h want 001/6000", nzp, ip); end
  endtask

  task automatic test_call_ret;
    run_inst(5'b10001, 3'b000, 16'h8000, 16'h5000, 1'b0);
    checks++; if ({obs_we_wb, obs_link_wb} !== 2'b11) begin errors++;
      $display("FAIL call_wb we/link got %b want 11", {obs_we_wb, obs_link_wb}); end
    checks++; if ({ip, nzp} !== {16'h5000, 3'b001}) begin errors++;
      $display("FAIL call_after ip/nzp got %h/%b want 5000/001", ip, nzp); end
    run_inst(5'b00000, 3'b000, 16'h0000, 16'h3001, 1'b0);
    checks++; if ({obs_we_wb, obs_link_wb} !== 2'b00) begin errors++;
      $display("FAIL ret_wb we/link got %b want 00", {obs_we_wb, obs_link_wb}); end
    checks++; if ({ip, nzp} !== {16'h3001, 3'b001}) begin errors++;
      $display("FAIL ret_after ip/nzp got %h/%b want 3001/001", ip, nzp); end
  endtask

  task automatic test_illegal;
    run_inst(5'b11111, 3'b000, 16'h0000, 16'h7777, 1'b0);
    checks++; if ({illegal, obs_we_wb, ip, nzp} !== {1'b1, 1'b0, 16'h3002, 3'b001}) begin errors++;
      $display("FAIL illegal ill/we/ip/nzp got %b/%b/%h/%b want 1/0/3002/001", illegal, obs_we_wb, ip, nzp); end
    run_inst(5'b00101, 3'b000, 16'hFFFF, 16'h0000, 1'b0);
    checks++; if ({illegal, ip, nzp} !== {1'b1, 16'h3003, 3'b100}) begin errors++;
      $display("FAIL illegal_sticky ill/ip/nzp got %b/%h/%b want 1/3003/100", illegal, ip, nzp); end
    run_inst(5'b00111, 3'b000, 16'h0000, 16'h0000, 1'b1);
    checks++; if (obs_we_wb !== 1'b1) begin errors++; $display("FAIL pre_abort_we got %b want 1", obs_we_wb); end
    rst_n = 1'b0;
    #1;
    checks++; if ({rf_we, busy, illegal, ip, nzp} !== {3'b000, 16'h3000, 3'b010}) begin errors++;
      $display("FAIL abort we/busy/ill/ip/nzp got %b%b%b/%h/%b want 000/3000/010", rf_we, busy, illegal, ip, nzp); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({ip, inst_ready, retired_cnt} !== {16'h3000, 1'b1, 32'd0}) begin errors++;
      $display("FAIL post_abort ip/ready/cnt got %h/%b/%0d want 3000/1/0", ip, inst_ready, retired_cnt); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 5; i++) begin
      run_inst(5'b00100 + 5'(i % 4), 3'b000, 16'(i + 1), 16'h0000, 1'b0);
      checks++; if ({obs_ready_acc, obs_ready_wb, inst_ready} !== 3'b001) begin errors++;
        $display("FAIL b2b_ready[%0d] got %b want 001", i, {obs_ready_acc, obs_ready_wb, inst_ready}); end
    end
    checks++; if ({ip, nzp} !== {16'h3005, 3'b001}) begin errors++;
      $display("FAIL b2b_after ip/nzp got %h/%b want 3005/001", ip, nzp); end
`ifdef PERF_CNT_EN
    checks++; if (retired_cnt !== 32'd5) begin errors++; $display("FAIL b2b_cnt got %0d want 5", retired_cnt); end
`else
    checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL b2b_cnt got %0d want 0", retired_cnt); end
`endif
  endtask

  task automatic test_wrap;
    run_inst(5'b00000, 3'b000, 16'h0000, 16'hFFFF, 1'b0);
    checks++; if (ip !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %h want ffff", ip); end
    run_inst(5'b00101, 3'b000, 16'h7FFF, 16'h1111, 1'b0);
    checks++; if ({ip, nzp} !== {16'h0000, 3'b001}) begin errors++;
      $display("FAIL wrap ip/nzp got %h/%b want 0000/001", ip, nzp); end
`ifdef PERF_CNT_EN
    checks++; if (retired_cnt !== 32'd7) begin errors++; $display("FAIL wrap_cnt got %0d want 7", retired_cnt); end
`endif
  endtask

  initial begin
    test_reset;
    test_alu;
    test_branch;
    test_call_ret;
    test_illegal;
    test_back_to_back;
    test_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
